// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: read-owner tags and the
// access bundle presented to the SRAM macro.
package mem_port_arbiter_pkg;

    localparam int MA_ADDR_W = 20;
    localparam int MA_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_TB   = 2'd3
    } arb_owner_e;

    typedef struct packed {
        logic                   we;
        logic [MA_ADDR_W-1:0]   addr;
        logic [MA_DATA_W-1:0]   wdata;
        logic [MA_DATA_W/8-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/return bundle between loader, FETCH, MEM and the SRAM.
// The arbiter takes the slave side; requesters and the SRAM take master.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic                TB_LOAD_CTRL;
    logic [ADDR_W-1:0]   TB_LOAD_ADDR;
    logic [DATA_W-1:0]   TB_LOAD_DATA;

    logic                D_REQ;
    logic                D_WE;
    logic [ADDR_W-1:0]   D_ADDR;
    logic [DATA_W-1:0]   D_WDATA;
    logic [DATA_W/8-1:0] D_BE;
    logic                D_GNT;
    logic                D_RVALID;
    logic [DATA_W-1:0]   D_RDATA;

    logic                I_REQ;
    logic [ADDR_W-1:0]   I_ADDR;
    logic                I_GNT;
    logic                I_RVALID;
    logic [DATA_W-1:0]   I_RDATA;

    logic                MEM_CSB;
    logic                MEM_WEB;
    logic [ADDR_W-1:0]   MEM_ADDR;
    logic [DATA_W/8-1:0] MEM_WMASK;
    logic [DATA_W-1:0]   MEM_DIN;
    logic [DATA_W-1:0]   MEM_DOUT;

    logic                STALL;

    modport slave (
        input  TB_LOAD_CTRL, TB_LOAD_ADDR, TB_LOAD_DATA,
        input  D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
        output D_GNT, D_RVALID, D_RDATA,
        input  I_REQ, I_ADDR,
        output I_GNT, I_RVALID, I_RDATA,
        output MEM_CSB, MEM_WEB, MEM_ADDR, MEM_WMASK, MEM_DIN,
        input  MEM_DOUT,
        output STALL
    );

    modport master (
        output TB_LOAD_CTRL, TB_LOAD_ADDR, TB_LOAD_DATA,
        output D_REQ, D_WE, D_ADDR, D_WDATA, D_BE,
        input  D_GNT, D_RVALID, D_RDATA,
        output I_REQ, I_ADDR,
        input  I_GNT, I_RVALID, I_RDATA,
        input  MEM_CSB, MEM_WEB, MEM_ADDR, MEM_WMASK, MEM_DIN,
        output MEM_DOUT,
        input  STALL
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts cycles in which fetch loses to data; force_i lets fetch
// through once the count reaches STARVE_LIM.
module mem_arb_starve_ctr #(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_gnt,
    input  logic i_gnt,
    output logic force_i
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_req || i_gnt) begin
            cnt_d = '0;
        end else if (d_gnt) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_i = (cnt_q == CW'(STARVE_LIM));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: loader > data > fetch, 1-cycle read return.
// Define MEMARB_STARVE_GUARD_EN to let starved fetch past data.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = MA_ADDR_W,
    parameter int DATA_W = MA_DATA_W
`ifdef MEMARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIM = 4
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    mem_port_arbiter_if.slave bus
);

    arb_owner_e rd_owner_q;
    arb_owner_e rd_owner_d;
    mem_req_t   req;
    logic       d_gnt;
    logic       i_gnt;
    logic       csb;
    logic       force_i;

`ifdef MEMARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_LIM (STARVE_LIM)
    ) u_starve (
        .clk     (CLK),
        .rst     (RST),
        .i_req   (bus.I_REQ),
        .d_gnt   (d_gnt),
        .i_gnt   (i_gnt),
        .force_i (force_i)
    );
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        d_gnt      = 1'b0;
        i_gnt      = 1'b0;
        csb        = 1'b1;
        req        = '0;
        rd_owner_d = OWN_NONE;
        if (!RST) begin
            if (bus.TB_LOAD_CTRL) begin
                csb        = 1'b0;
                req.we     = 1'b1;
                req.addr   = bus.TB_LOAD_ADDR;
                req.wdata  = bus.TB_LOAD_DATA;
                req.be     = '1;
                rd_owner_d = OWN_TB;
            end else if (bus.D_REQ && !(force_i && bus.I_REQ)) begin
                d_gnt      = 1'b1;
                csb        = 1'b0;
                req.we     = bus.D_WE;
                req.addr   = bus.D_ADDR;
                req.wdata  = bus.D_WDATA;
                req.be     = bus.D_WE ? bus.D_BE : '0;
                rd_owner_d = bus.D_WE ? OWN_NONE : OWN_D;
            end else if (bus.I_REQ) begin
                i_gnt      = 1'b1;
                csb        = 1'b0;
                req.addr   = bus.I_ADDR;
                rd_owner_d = OWN_I;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign bus.D_GNT     = d_gnt;
    assign bus.I_GNT     = i_gnt;
    assign bus.MEM_CSB   = csb;
    assign bus.MEM_WEB   = csb | !req.we;
    assign bus.MEM_ADDR  = req.addr;
    assign bus.MEM_WMASK = req.be;
    assign bus.MEM_DIN   = req.wdata;

    // Both read ports see the raw macro output; RVALID qualifies it.
    assign bus.D_RDATA  = bus.MEM_DOUT;
    assign bus.I_RDATA  = bus.MEM_DOUT;
    assign bus.D_RVALID = (rd_owner_q == OWN_D);
    assign bus.I_RVALID = (rd_owner_q == OWN_I);

    assign bus.STALL = !RST &&
                       ((bus.D_REQ && !d_gnt) || (bus.I_REQ && !i_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural SRAM model.
module tb_mem_port_arbiter;

    logic CLK;
    logic RST;
    int   n_pass;
    int   n_total;

    mem_port_arbiter_if #(.ADDR_W(20), .DATA_W(32)) bus ();

    mem_port_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [31:0] sram [0:255];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (!bus.MEM_CSB) begin
            if (!bus.MEM_WEB) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.MEM_WMASK[b]) begin
                        sram[bus.MEM_ADDR[7:0]][b*8 +: 8] <= bus.MEM_DIN[b*8 +: 8];
                    end
                end
            end else begin
                bus.MEM_DOUT <= sram[bus.MEM_ADDR[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.TB_LOAD_CTRL = 1'b0;
        bus.TB_LOAD_ADDR = '0;
        bus.TB_LOAD_DATA = '0;
        bus.D_REQ        = 1'b0;
        bus.D_WE         = 1'b0;
        bus.D_ADDR       = '0;
        bus.D_WDATA      = '0;
        bus.D_BE         = '0;
        bus.I_REQ        = 1'b0;
        bus.I_ADDR       = '0;
    endtask

    logic [31:0] ld_data [0:2];
    logic        exp_ig;
    logic        prev_dg;

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int i = 0; i < 256; i++) sram[i] = '0;
        bus.MEM_DOUT = '0;
        ld_data[0] = 32'h0050_0093;
        ld_data[1] = 32'h00A0_0113;
        ld_data[2] = 32'h0020_81B3;
        idle_inputs();
        RST = 1'b1;

        // reset: pending fetch must not grant or stall
        #2;
        bus.I_REQ = 1'b1;
        settle();
        chk("rst_i_gnt", 32'(bus.I_GNT), 32'd0);
        chk("rst_csb", 32'(bus.MEM_CSB), 32'd1);
        chk("rst_web", 32'(bus.MEM_WEB), 32'd1);
        chk("rst_stall", 32'(bus.STALL), 32'd0);
        chk("rst_rvalid", {30'd0, bus.I_RVALID, bus.D_RVALID}, 32'd0);
        next_cycle();
        RST = 1'b0;

        // loader writes three words while fetch waits
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            bus.TB_LOAD_CTRL = 1'b1;
            bus.TB_LOAD_ADDR = 20'(i);
            bus.TB_LOAD_DATA = ld_data[i];
            bus.I_REQ        = 1'b1;
            bus.I_ADDR       = 20'd1;
            settle();
            chk("ld_web", 32'(bus.MEM_WEB), 32'd0);
            chk("ld_i_gnt", 32'(bus.I_GNT), 32'd0);
            chk("ld_stall", 32'(bus.STALL), 32'd1);
            chk("ld_wmask", 32'(bus.MEM_WMASK), 32'hF);
        end

        // first cycle after loader: fetch word 1 granted
        next_cycle();
        bus.TB_LOAD_CTRL = 1'b0;
        settle();
        chk("post_ld_i_gnt", 32'(bus.I_GNT), 32'd1);
        chk("post_ld_stall", 32'(bus.STALL), 32'd0);
        chk("post_ld_rvalid", {30'd0, bus.I_RVALID, bus.D_RVALID}, 32'd0);
        next_cycle();
        bus.I_REQ = 1'b0;
        settle();
        chk("fetch_rvalid", 32'(bus.I_RVALID), 32'd1);
        chk("fetch_rdata", bus.I_RDATA, 32'h00A0_0113);
        chk("fetch_d_rvalid", 32'(bus.D_RVALID), 32'd0);
        chk("idle_csb", 32'(bus.MEM_CSB), 32'd1);

        // data write beats fetch
        next_cycle();
        bus.D_REQ   = 1'b1;
        bus.D_WE    = 1'b1;
        bus.D_ADDR  = 20'h40;
        bus.D_WDATA = 32'hDEAD_BEEF;
        bus.D_BE    = 4'b0010;
        bus.I_REQ   = 1'b1;
        bus.I_ADDR  = 20'd2;
        settle();
        chk("cont_d_gnt", 32'(bus.D_GNT), 32'd1);
        chk("cont_i_gnt", 32'(bus.I_GNT), 32'd0);
        chk("cont_wmask", 32'(bus.MEM_WMASK), 32'b0010);
        chk("cont_web", 32'(bus.MEM_WEB), 32'd0);
        chk("cont_addr", 32'(bus.MEM_ADDR), 32'h40);
        chk("cont_stall", 32'(bus.STALL), 32'd1);
        next_cycle();
        bus.D_REQ = 1'b0;
        settle();
        chk("cont_i_gnt2", 32'(bus.I_GNT), 32'd1);
        chk("cont_no_drv", 32'(bus.D_RVALID), 32'd0);
        // read granted, loader rises next cycle: data still returned
        next_cycle();
        bus.I_REQ        = 1'b0;
        bus.TB_LOAD_CTRL = 1'b1;
        bus.TB_LOAD_ADDR = 20'd3;
        bus.TB_LOAD_DATA = 32'h1234_5678;
        settle();
        chk("ld_rise_i_rvalid", 32'(bus.I_RVALID), 32'd1);
        chk("ld_rise_i_rdata", bus.I_RDATA, 32'h0020_81B3);
        chk("ld_rise_d_rvalid", 32'(bus.D_RVALID), 32'd0);
        next_cycle();
        bus.TB_LOAD_CTRL = 1'b0;
        settle();
        chk("after_ld_rvalid", {30'd0, bus.I_RVALID, bus.D_RVALID}, 32'd0);

        // starvation: both held for eight cycles
        prev_dg = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            bus.D_REQ  = 1'b1;
            bus.D_WE   = 1'b0;
            bus.D_ADDR = 20'd0;
            bus.I_REQ  = 1'b1;
            bus.I_ADDR = 20'd0;
            settle();
`ifdef MEMARB_STARVE_GUARD_EN
            exp_ig = (k == 5);
`else
            exp_ig = 1'b0;
`endif
            chk($sformatf("starve_i_gnt_%0d", k), 32'(bus.I_GNT), 32'(exp_ig));
            chk($sformatf("starve_d_gnt_%0d", k), 32'(bus.D_GNT), 32'(!exp_ig));
            chk($sformatf("starve_d_rv_%0d", k), 32'(bus.D_RVALID), 32'(prev_dg));
            prev_dg = !exp_ig;
        end
        next_cycle();
        bus.D_REQ = 1'b0;
        settle();
        chk("starve_release", 32'(bus.I_GNT), 32'd1);
        next_cycle();
        bus.I_REQ = 1'b0;
        settle();
        chk("starve_last_irv", 32'(bus.I_RVALID), 32'd1);

        // reset arriving the cycle after a data read
        next_cycle();
        bus.D_REQ  = 1'b1;
        bus.D_WE   = 1'b0;
        bus.D_ADDR = 20'd0;
        settle();
        chk("rstrd_d_gnt", 32'(bus.D_GNT), 32'd1);
        next_cycle();
        bus.D_REQ = 1'b0;
        bus.I_REQ = 1'b1;
        RST       = 1'b1;
        settle();
        chk("rstrd_d_rvalid", 32'(bus.D_RVALID), 32'd0);
        chk("rstrd_csb", 32'(bus.MEM_CSB), 32'd1);
        chk("rstrd_stall", 32'(bus.STALL), 32'd0);
        chk("rstrd_i_gnt", 32'(bus.I_GNT), 32'd0);
        next_cycle();
        RST       = 1'b0;
        bus.I_REQ = 1'b0;
        settle();
        chk("rstrd_owner_none", {30'd0, bus.I_RVALID, bus.D_RVALID}, 32'd0);

        // back-to-back: data read of the masked write, then fetch word 0
        next_cycle();
        bus.D_REQ  = 1'b1;
        bus.D_WE   = 1'b0;
        bus.D_ADDR = 20'h40;
        settle();
        chk("b2b_d_gnt", 32'(bus.D_GNT), 32'd1);
        next_cycle();
        bus.D_REQ  = 1'b0;
        bus.I_REQ  = 1'b1;
        bus.I_ADDR = 20'd0;
        settle();
        chk("b2b_d_rvalid", 32'(bus.D_RVALID), 32'd1);
        chk("b2b_d_rdata", bus.D_RDATA, 32'h0000_BE00);
        chk("b2b_i_gnt", 32'(bus.I_GNT), 32'd1);
        chk("b2b_i_rv_early", 32'(bus.I_RVALID), 32'd0);
        next_cycle();
        bus.I_REQ = 1'b0;
        settle();
        chk("b2b_i_rvalid", 32'(bus.I_RVALID), 32'd1);
        chk("b2b_i_rdata", bus.I_RDATA, 32'h0050_0093);
        chk("b2b_d_rv_late", 32'(bus.D_RVALID), 32'd0);

        next_cycle();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-port instruction/data SRAM shared by the testbench program loader, the MEM-stage load/store path and the FETCH stage. Each cycle it grants the SRAM port to at most one requester and routes read data back one cycle later to whoever issued the read. It raises a pipeline stall whenever a pipeline requester is held off. It sits between the FETCH and MEMORY blocks and the SRAM macro, and replaces their separate chip-select/write-enable logic.

## Interface
Parameters:
- ADDR_W, 20, SRAM word address width
- DATA_W, 32, data width; must be a multiple of 8
- STARVE_LIM, 4, starvation limit for fetch; used only when MEMARB_STARVE_GUARD_EN is defined

Ports:
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-high reset
- TB_LOAD_CTRL  in  1  loader active; highest priority
- TB_LOAD_ADDR  in  ADDR_W  loader write address
- TB_LOAD_DATA  in  DATA_W  loader write data
- D_REQ  in  1  data request; held until granted
- D_WE  in  1  data request is a write (1) or read (0)
- D_ADDR  in  ADDR_W  data address
- D_WDATA  in  DATA_W  store data
- D_BE  in  DATA_W/8  byte enables for writes
- D_GNT  out  1  data request accepted this cycle
- D_RVALID  out  1  D_RDATA valid
- D_RDATA  out  DATA_W  load data
- I_REQ  in  1  fetch read request; held until granted
- I_ADDR  in  ADDR_W  fetch address
- I_GNT  out  1  fetch request accepted this cycle
- I_RVALID  out  1  I_RDATA valid
- I_RDATA  out  DATA_W  instruction word
- MEM_CSB  out  1  SRAM chip select, active-low
- MEM_WEB  out  1  SRAM write enable, active-low
- MEM_ADDR  out  ADDR_W  SRAM address
- MEM_WMASK  out  DATA_W/8  SRAM byte write mask
- MEM_DIN  out  DATA_W  SRAM write data
- MEM_DOUT  in  DATA_W  SRAM read data; valid the cycle after a read access
- STALL  out  1  pipeline stall: a pipeline request is pending and not granted

## Operation
- **Priority:** TB_LOAD_CTRL > D_REQ > I_REQ. Grant decisions are combinational from the current requests and the registered state.
- **Loader access:** while TB_LOAD_CTRL is high:
  - Every cycle is a write: MEM_CSB=0, MEM_WEB=0, MEM_WMASK all ones.
  - MEM_ADDR and MEM_DIN come from the TB_LOAD_* inputs.
  - D_GNT=0 and I_GNT=0.
- **Granted pipeline access:**
  - MEM_CSB=0.
  - MEM_WEB = !D_WE for data, 1 for fetch.
  - MEM_WMASK = D_BE on data writes, otherwise 0.
  - The address (and write data) are taken from the granted requester.
- **Read-owner register:** `rd_owner` takes one of OWN_NONE / OWN_I / OWN_D / OWN_TB.
  - It loads OWN_I or OWN_D on a granted read, OWN_TB on a loader write, and OWN_NONE otherwise.
  - When rd_owner is OWN_I, I_RVALID=1; when it is OWN_D, D_RVALID=1.
  - I_RDATA and D_RDATA are both driven directly from MEM_DOUT; the RVALIDs qualify them.
- **Writes:** complete at the grant edge. No RVALID is returned.
- **STALL** = (D_REQ & !D_GNT) | (I_REQ & !I_GNT).
- **No request:** MEM_CSB=1, MEM_WEB=1, MEM_WMASK=0.
- **Reset (RST high):**
  - rd_owner becomes OWN_NONE and the starvation counter becomes 0.
  - While RST is high, all GNT and RVALID outputs are 0, MEM_CSB=1, MEM_WEB=1 and STALL=0.
- **Boundary conditions:**
  - A read granted in cycle N still returns RVALID in N+1, even if TB_LOAD_CTRL rises in N+1.
  - RST asserted in N+1 suppresses that RVALID.
  - In the first cycle after TB_LOAD_CTRL falls, pipeline requests arbitrate normally.

## Timing
- Grant is in the same cycle as the request (0-cycle latency when uncontended).
- Read data arrives exactly 1 cycle after the grant.
- Throughput is 1 access per cycle; back-to-back reads from different owners are allowed. In cycle N+1, RVALID for access N and a grant for access N+1 coexist.
- A contended requester waits until every higher-priority request drops, subject to the starvation guard.

## Configuration
- **MEMARB_STARVE_GUARD_EN defined:**
  - A counter increments each cycle in which I_REQ=1 and D_GNT=1.
  - When the counter equals STARVE_LIM, the next cycle with D_REQ and I_REQ both high grants fetch instead of data, and the counter clears.
  - The counter also clears on any I_GNT and whenever I_REQ=0.
  - The loader still overrides everything.
- **Undefined:** strict fixed priority and no counter logic; STARVE_LIM is unused.

## Structure
- my_pkg gains:
  - `arb_owner_e` (OWN_NONE, OWN_I, OWN_D, OWN_TB, 2 bits)
  - `mem_req_t` struct {we, addr, wdata, be}
- One sub-module, `mem_arb_starve_ctr` (counter plus limit compare, output `force_i`), instantiated only under MEMARB_STARVE_GUARD_EN.

## Test plan
- **Loader priority:** TB_LOAD_CTRL=1, writes 0x00500093/0x00A00113/0x002081B3 to addresses 0,1,2, with I_REQ=1 throughout -> MEM_WEB=0 on each cycle, I_GNT=0, STALL=1; I_GNT=1 in the first cycle after TB_LOAD_CTRL falls.
- **Uncontended fetch:** I_REQ, I_ADDR=1, with SRAM word 1 = 0x00A00113 -> I_GNT=1 in cycle N; I_RVALID=1 and I_RDATA=0x00A00113 in N+1.
- **Contention:** D_REQ write (addr 0x40, data 0xDEADBEEF, D_BE=4'b0010) and I_REQ in the same cycle -> D_GNT=1, MEM_WMASK=0010, STALL=1; I_GNT=1 the next cycle; no D_RVALID.
- **Starvation:** D_REQ and I_REQ both held for 8 cycles.
  - With MEMARB_STARVE_GUARD_EN and STARVE_LIM=4: I_GNT=1 in cycle 5, then D_GNT in cycles 6-8.
  - Without the macro: I_GNT=0 until D_REQ drops.
- **Reset mid-read:** D read granted in cycle N, RST=1 in N+1 -> D_RVALID=0, MEM_CSB=1, STALL=0; after RST releases, rd_owner is OWN_NONE.
- **Back-to-back reads:** D read granted in N, I read granted in N+1 -> D_RVALID in N+1, I_RVALID in N+2, each carrying its own MEM_DOUT word.
